// File: rtl/spi_rb_bridge.sv
// spi_rb_bridge
// SPI slave (mode 0, MSB first) that acts as master of the toi2s register-bank bus.
// A frame is: command byte, address byte, then one or more data bytes. The address
// auto-increments after each data byte. Command 0x02 is a write and 0x03 is a read.
// Any other command is ignored until chip select is released.
// The SPI pins are asynchronous. They are synchronised and oversampled in the clk
// domain, so SCK high and low phases must each last at least 8 clk periods.
//
// Ports
//   clk            system clock
//   resetb         synchronous, active-low reset
//   spi_csn        SPI chip select, active low (async)
//   spi_sck        SPI clock, idle low (async)
//   spi_mosi       SPI data in (async)
//   spi_miso       SPI data out (tx_sr[7] during read data, else 0)
//   spi_miso_oe    MISO output enable, high while synchronised csn is low
//   address        register-bus address
//   data_write_in  register-bus write data
//   data_read_out  register-bus read data, valid 1 clk after address changes
//   reg_en         high while a frame is active
//   write_en       single-clk write strobe
module spi_rb_bridge #(
    parameter int ADR_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                spi_csn,
    input  logic                spi_sck,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic [ADR_BITS-1:0] address,
    output logic [7:0]          data_write_in,
    input  logic [7:0]          data_read_out,
    output logic                reg_en,
    output logic                write_en
);

    localparam int NEW = SYNC_STAGES - 2;
    localparam int OLD = SYNC_STAGES - 1;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
    logic                   csn_fall, csn_rise, sck_rise, sck_fall, mosi_bit;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sr, tx_sr, rx_byte;
    logic                   rd_mode;
    logic                   frame_on, byte_done;
    logic                   rd_ld_p0, rd_ld_p1, rd_inc_p0;
    logic                   miso_oe_q;

    // Input synchronisers. csn resets low so that leaving reset while a frame is
    // still in progress cannot create a csn_fall. The bridge then waits for the
    // next real chip-select assertion.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            csn_sync  <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign csn_fall = csn_sync[OLD] & ~csn_sync[NEW];
    assign csn_rise = ~csn_sync[OLD] & csn_sync[NEW];
    assign sck_rise = ~sck_sync[OLD] & sck_sync[NEW];
    assign sck_fall = sck_sync[OLD] & ~sck_sync[NEW];
    assign mosi_bit = mosi_sync[NEW];

    // A csn_fall that coincides with the first sck_rise still opens the frame.
    // In that case the same edge is counted as bit 7 of the command byte.
    assign frame_on  = (state != IDLE) || csn_fall;
    assign rx_byte   = {rx_sr[6:0], mosi_bit};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csn_fall) state_nxt = CMD;
            CMD:     if (byte_done) begin
                         if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) state_nxt = ADDR;
                         else                                            state_nxt = IGNORE;
                     end
            ADDR:    if (byte_done) state_nxt = rd_mode ? RDATA : WDATA;
            default: state_nxt = state;
        endcase
        if (csn_rise) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            bit_cnt       <= 3'd0;
            rx_sr         <= 8'h00;
            tx_sr         <= 8'h00;
            rd_mode       <= 1'b0;
            address       <= '0;
            data_write_in <= 8'h00;
            write_en      <= 1'b0;
            rd_ld_p0      <= 1'b0;
            rd_ld_p1      <= 1'b0;
            rd_inc_p0     <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            write_en  <= 1'b0;
            rd_ld_p0  <= 1'b0;
            rd_inc_p0 <= 1'b0;
            rd_ld_p1  <= rd_ld_p0;

            if (csn_fall) miso_oe_q <= 1'b1;
            if (csn_rise) miso_oe_q <= 1'b0;

            // Releasing chip select throws away any partial byte.
            if (csn_rise) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise && frame_on) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte;
            end

            // The first fall after a byte boundary leaves bit 7 on MISO for the
            // master's next rising edge.
            if (sck_fall && frame_on && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b0};

            if (byte_done) begin
                case (state)
                    CMD:   rd_mode <= (rx_byte == CMD_READ);
                    ADDR:  begin
                               address  <= ADR_BITS'(rx_byte);
                               rd_ld_p0 <= rd_mode;
                           end
                    WDATA: begin
                               data_write_in <= rx_byte;
                               write_en      <= 1'b1;
                           end
                    RDATA: begin
                               tx_sr     <= data_read_out;
                               rd_inc_p0 <= 1'b1;
                           end
                    default: ;
                endcase
            end

            // Stage p1 of the first-read prefetch. The bus data for the new
            // address is valid now, so capture it and move on to the next address.
            if (rd_ld_p1) begin
                tx_sr   <= data_read_out;
                address <= address + ADR_BITS'(1);
            end

            // Post-byte increment. It runs after a write strobe or after a read
            // capture, and wraps naturally at the top of the address space.
            if (rd_inc_p0 || write_en) address <= address + ADR_BITS'(1);
        end
    end

    assign reg_en      = (state != IDLE);
    assign spi_miso    = (state == RDATA) ? tx_sr[7] : 1'b0;
    assign spi_miso_oe = miso_oe_q;

endmodule

// File: tb/tb_spi_rb_bridge.sv
// Testbench for spi_rb_bridge. A behavioural register bank answers reads one clk
// after the address changes. A scoreboard holds the expected write strobes and
// read bytes.
module tb_spi_rb_bridge;

    localparam int HALF = 100;   // SCK half period in ns (10 clk)

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, reg_en, write_en;
    logic [7:0] address, data_write_in, data_read_out;

    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];
    logic [7:0]  buf_d   [8];
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    spi_rb_bridge #(.ADR_BITS(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .resetb        (resetb),
        .spi_csn       (spi_csn),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .address       (address),
        .data_write_in (data_write_in),
        .data_read_out (data_read_out),
        .reg_en        (reg_en),
        .write_en      (write_en)
    );

    function automatic logic [7:0] rb_default(input int a);
        case (a)
            'h01:    return 8'h85;
            'h18:    return 8'h40;
            'h19:    return 8'h18;
            'h1A:    return 8'h53;
            'h1B:    return 8'h08;
            default: return 8'(a) ^ 8'h5A;
        endcase
    endfunction

    // Register bank: registered read, write on strobe.
    always @(posedge clk) begin
        if (!resetb) begin
            for (int i = 0; i < 256; i++) mem[i] <= rb_default(i);
            data_read_out <= 8'h00;
        end else begin
            if (write_en) mem[address] <= data_write_in;
            data_read_out <= mem[address];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write-strobe monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (resetb && write_en) begin
            if (wq.size() == 0) begin
                check("we_unexpected", {24'h0, address}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = wq.pop_front();
                check("we_addr", address, e[15:8]);
                check("we_data", data_write_in, e[7:0]);
            end
        end
    end

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            #HALF;
            spi_sck = 1'b1;
            rx[i] = spi_miso;
            #HALF;
            spi_sck = 1'b0;
        end
    endtask

    task automatic csn_low();
        @(negedge clk);
        spi_csn = 1'b0;
        #HALF;
    endtask

    task automatic csn_high();
        #HALF;
        spi_csn = 1'b1;
        #(4 * HALF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso", spi_miso, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_address", address, 0);
        check("rst_wdata", data_write_in, 0);
        check("rst_reg_en", reg_en, 0);
        check("rst_write_en", write_en, 0);
        for (int i = 0; i < 256; i++) exp_mem[i] = rb_default(i);
        resetb = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr_frame(input logic [7:0] a, input int n);
        logic [7:0] rx, ad;
        csn_low();
        xfer(8'h02, 8, rx);
        xfer(a, 8, rx);
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            wq.push_back({ad, buf_d[i]});
            exp_mem[ad] = buf_d[i];
            xfer(buf_d[i], 8, rx);
        end
        csn_high();
    endtask

    task automatic rd_frame(input logic [7:0] a, input int n);
        logic [7:0] rx, ad;
        csn_low();
        xfer(8'h03, 8, rx);
        xfer(a, 8, rx);
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            rq.push_back(exp_mem[ad]);
            xfer(8'h00, 8, rx);
            check("rd_data", rx, rq.pop_front());
        end
        csn_high();
    endtask

    initial begin
        logic [7:0] rx;

        do_reset();

        // T1: single write
        buf_d[0] = 8'hA5;
        wr_frame(8'h01, 1);
        check("t1_pwm_duty", mem[1], 8'hA5);
        check("t1_reg_en_off", reg_en, 0);

        // T2: burst write and readback
        buf_d[0] = 8'h11; buf_d[1] = 8'h22; buf_d[2] = 8'h33; buf_d[3] = 8'h44;
        wr_frame(8'h18, 4);
        rd_frame(8'h18, 4);

        // T3: reset values through burst read
        do_reset();
        rd_frame(8'h18, 4);
        rd_frame(8'h01, 1);

        // T4: unknown command
        csn_low();
        xfer(8'h55, 8, rx);
        check("t4_reg_en_on", reg_en, 1);
        for (int i = 0; i < 3; i++) begin
            xfer(8'($urandom_range(0, 255)), 8, rx);
            check("t4_miso_zero", rx, 0);
        end
        check("t4_miso_oe", spi_miso_oe, 1);
        csn_high();
        check("t4_reg_en_off", reg_en, 0);
        check("t4_miso_oe_off", spi_miso_oe, 0);

        // T5: partial data byte aborted
        csn_low();
        xfer(8'h02, 8, rx);
        xfer(8'h30, 8, rx);
        xfer(8'hE7, 5, rx);
        csn_high();
        buf_d[0] = 8'h77;
        wr_frame(8'h31, 1);
        rd_frame(8'h30, 2);

        // T6: wrap from 0xFF, then reset mid-frame
        buf_d[0] = 8'hC1; buf_d[1] = 8'hC2;
        wr_frame(8'hFF, 2);
        rd_frame(8'hFF, 2);
        csn_low();
        xfer(8'h02, 8, rx);
        xfer(8'h40, 8, rx);
        xfer(8'hFF, 3, rx);
        do_reset();
        xfer(8'hFF, 5, rx);
        xfer(8'h3C, 8, rx);
        check("t6_idle_reg_en", reg_en, 0);
        check("t6_idle_miso_oe", spi_miso_oe, 0);
        csn_high();
        buf_d[0] = 8'h99;
        wr_frame(8'h05, 1);
        rd_frame(8'h05, 1);

        check("wq_drained", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
